// File: rtl/vga_pkg.sv
// Shared map/VGA types and the map fill pattern.
// Build option: define MAP_BORDER_EN to make the fill draw a solid arena border.
package vga_pkg;

  localparam int MAP_ADDR_W = 14;
  localparam int MAP_DATA_W = 12;
  localparam logic [MAP_DATA_W-1:0] COLOR_SOLID = 12'h000;

  typedef enum logic {FILL, READY} map_fsm_t;

  // Colour written at a given map address while the map is being rebuilt.
  function automatic logic [MAP_DATA_W-1:0] map_fill_color(
    input logic [MAP_ADDR_W-1:0] adr,
    input logic [MAP_DATA_W-1:0] bg,
    input logic [5:0]            floor_row
  );
    logic solid;
    solid = (adr[13:8] >= floor_row);
`ifdef MAP_BORDER_EN
    solid = solid | (adr[7:0] == 8'h00) | (adr[7:0] == 8'hFF) | (adr[13:8] == 6'd0);
`else
    solid = solid;
`endif
    return solid ? COLOR_SOLID : bg;
  endfunction

endpackage

// File: rtl/map_ram.sv
// Single-clock map RAM: port A read/write, port B read-only, read-first.
// No reset on the array or read registers so it maps onto block RAM.
module map_ram
  import vga_pkg::*;
#(
  parameter int ADDR_W = MAP_ADDR_W,
  parameter int DATA_W = MAP_DATA_W
) (
  input  logic              clk,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_adr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [ADDR_W-1:0] b_adr_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // A write cycle leaves the port A read register untouched.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_adr_i] <= a_wdata_i;
    end else begin
      a_rdata_q <= mem_q[a_adr_i];
    end
  end

  always_ff @(posedge clk) begin
    b_rdata_q <= mem_q[b_adr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/map_pixel_server.sv
// Map pixel responder: fills the map from a pattern, then serves two read ports plus edits.
// Build option: MAP_BORDER_EN (see vga_pkg) adds a solid border to the fill pattern.
module map_pixel_server
  import vga_pkg::*;
#(
  parameter int                ADDR_W    = MAP_ADDR_W,
  parameter int                DATA_W    = MAP_DATA_W,
  parameter logic [DATA_W-1:0] BG_COLOR  = 12'h8CF,
  parameter int                FLOOR_ROW = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic [ADDR_W-1:0] pixel_adr,
  output logic [DATA_W-1:0] rgb_pixel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] vga_adr,
  output logic [DATA_W-1:0] vga_rgb,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] FILL_LAST = '1;

  map_fsm_t          state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              hide_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_a_rdata;
  logic [DATA_W-1:0] ram_b_rdata;
  logic              hide;

  // hide_q covers the first READY cycle, whose port A register still holds pre-fill data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      hide_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      hide_q     <= (state_q == FILL);
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    ram_we     = 1'b0;
    ram_adr    = pixel_adr;
    ram_wdata  = wr_data;
    case (state_q)
      FILL: begin
        ram_we    = 1'b1;
        ram_adr   = fill_cnt_q;
        ram_wdata = map_fill_color(fill_cnt_q, BG_COLOR, 6'(FLOOR_ROW));
        if (init_req) begin
          fill_cnt_d = '0;
        end else if (fill_cnt_q == FILL_LAST) begin
          state_d = READY;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      READY: begin
        if (init_req) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end else if (wr_en) begin
          ram_we  = 1'b1;
          ram_adr = wr_adr;
        end
      end
    endcase
  end

  map_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk       (clk),
    .a_we_i    (ram_we),
    .a_adr_i   (ram_adr),
    .a_wdata_i (ram_wdata),
    .a_rdata_o (ram_a_rdata),
    .b_adr_i   (vga_adr),
    .b_rdata_o (ram_b_rdata)
  );

  assign busy      = (state_q == FILL);
  assign hide      = busy | hide_q;
  assign rgb_pixel = hide ? COLOR_SOLID : ram_a_rdata;
  assign vga_rgb   = hide ? BG_COLOR : ram_b_rdata;

endmodule

// File: tb/tb_map_pixel_server.sv
// Directed bench for map_pixel_server; expectations queued by stimulus, checked by a monitor.
module tb_map_pixel_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic [13:0] pixel_adr;
  logic [11:0] rgb_pixel;
  logic        wr_en;
  logic [13:0] wr_adr;
  logic [11:0] wr_data;
  logic [13:0] vga_adr;
  logic [11:0] vga_rgb;
  logic        busy;

  map_pixel_server dut (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .pixel_adr (pixel_adr),
    .rgb_pixel (rgb_pixel),
    .wr_en     (wr_en),
    .wr_adr    (wr_adr),
    .wr_data   (wr_data),
    .vga_adr   (vga_adr),
    .vga_rgb   (vga_rgb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] BG    = 12'h8CF;
  localparam logic [11:0] SOLID = 12'h000;
`ifdef MAP_BORDER_EN
  localparam logic [11:0] EDGE_EXP = SOLID;
`else
  localparam logic [11:0] EDGE_EXP = BG;
`endif

  typedef struct {
    int          cyc;
    int          sel;   // 0 rgb_pixel, 1 vga_rgb, 2 busy
    logic [11:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input int sel, input logic [11:0] exp, input string nm);
    exp_t e;
    e.cyc = c; e.sel = sel; e.exp = exp; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation that is due this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [11:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = rgb_pixel;
        1:       act = vga_rgb;
        default: act = {11'b0, busy};
      endcase
      check(e.nm, {20'b0, act}, {20'b0, e.exp});
    end
  end

  // Count busy cycles, watch forced outputs, optionally issue an edit mid-fill.
  task automatic measure_fill(input string nm, input bit do_wr);
    int          n;
    logic [11:0] bad_rgb;
    logic [11:0] bad_vga;
    n = 0;
    bad_rgb = SOLID;
    bad_vga = BG;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (rgb_pixel !== SOLID && bad_rgb === SOLID) bad_rgb = rgb_pixel;
      if (vga_rgb !== BG && bad_vga === BG) bad_vga = vga_rgb;
      if (do_wr && n == 1000) begin
        wr_en = 1'b1; wr_adr = 14'h0105; wr_data = 12'hF00;
      end
      if (n == 1001) wr_en = 1'b0;
    end
    check({nm, "_busy_len"}, n, 16384);
    check({nm, "_rgb_forced"}, {20'b0, bad_rgb}, {20'b0, SOLID});
    check({nm, "_vga_forced"}, {20'b0, bad_vga}, {20'b0, BG});
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; init_req = 1'b0; pixel_adr = 14'h0105;
    wr_en = 1'b0; wr_adr = '0; wr_data = '0; vga_adr = '0;

    // Reset state
    step();
    push(cyc, 0, SOLID, "rst_rgb");
    push(cyc, 1, BG, "rst_vga");
    push(cyc, 2, 12'h001, "rst_busy");
    step();

    // 1: initial fill
    rst = 1'b1;
    measure_fill("t1", 1'b0);
    step();
    push(cyc + 1, 0, BG, "t1_mem_0105");

    // 2: floor boundary
    step(); pixel_adr = 14'h3C10; push(cyc + 1, 0, SOLID, "t2_row60");
    step(); pixel_adr = 14'h3B10; vga_adr = 14'h3FFF;
    push(cyc + 1, 0, BG, "t2_row59");
    push(cyc + 1, 1, SOLID, "t2_vga_floor");

    // 3: edit write, port A hold and port B read-first
    step();
    pixel_adr = 14'h3C10; vga_adr = 14'h0A0A;
    wr_en = 1'b1; wr_adr = 14'h0A0A; wr_data = 12'hF00;
    push(cyc + 1, 0, BG, "t3_a_held");
    push(cyc + 1, 1, BG, "t3_b_old");
    step();
    wr_en = 1'b0; pixel_adr = 14'h0A0A;
    push(cyc + 1, 1, 12'hF00, "t3_b_new");
    push(cyc + 1, 0, 12'hF00, "t3_a_new");

    // 4: restart mid-fill, edit during fill dropped
    step(); init_req = 1'b1; push(cyc + 1, 2, 12'h001, "t4_busy_rise");
    step(); init_req = 1'b0;
    repeat (5000) @(posedge clk);
    #1; init_req = 1'b1;
    step(); init_req = 1'b0;
    measure_fill("t4", 1'b1);
    step(); pixel_adr = 14'h0105; push(cyc + 1, 0, BG, "t4_fill_wr_dropped");
    step(); pixel_adr = 14'h0A0A; push(cyc + 1, 0, BG, "t4_edit_refilled");

    // 5: init_req beats wr_en
    step();
    init_req = 1'b1; wr_en = 1'b1; wr_adr = 14'h0202; wr_data = 12'hF00;
    step(); init_req = 1'b0; wr_en = 1'b0;
    measure_fill("t5", 1'b0);
    step(); pixel_adr = 14'h0202; push(cyc + 1, 0, BG, "t5_wr_dropped");

    // 6: border pattern, then asynchronous reset mid-read
    step(); pixel_adr = 14'h0500; push(cyc + 1, 0, EDGE_EXP, "t6_col0");
    step(); pixel_adr = 14'h05FF; push(cyc + 1, 0, EDGE_EXP, "t6_col255");
    step(); pixel_adr = 14'h0005; push(cyc + 1, 0, EDGE_EXP, "t6_row0");
    step();
    wr_en = 1'b1; wr_adr = 14'h0A0A; wr_data = 12'hF00;
    step();
    wr_en = 1'b0; pixel_adr = 14'h0A0A; vga_adr = 14'h0A0A;
    push(cyc + 1, 0, 12'hF00, "t6_pre_rst_rgb");
    push(cyc + 1, 1, 12'hF00, "t6_pre_rst_vga");
    step();
    step();
    rst = 1'b0;
    push(cyc, 0, SOLID, "t6_rst_rgb");
    push(cyc, 1, BG, "t6_rst_vga");
    push(cyc, 2, 12'h001, "t6_rst_busy");
    step();
    step();

    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: got no sample, expected %0h", e.nm, e.exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
